// File: rtl/trav_arb_if.sv
// Traversal arbiter bus interface.
// Groups the three upstream ray channels (valid/data in, stall out) and the single
// downstream channel to traversal (valid/data out, stall in).
//   slave  : arbiter side (consumes upstream rays, produces the granted ray)
//   master : environment side (sources and traversal sink)
interface trav_arb_if #(
    parameter int unsigned WIDTH = 32
);
    logic             sint_to_tarb_valid;
    logic [WIDTH-1:0] sint_to_tarb_data;
    logic             sint_to_tarb_stall;
    logic             ss_to_tarb_valid;
    logic [WIDTH-1:0] ss_to_tarb_data;
    logic             ss_to_tarb_stall;
    logic             trav_to_tarb_valid;
    logic [WIDTH-1:0] trav_to_tarb_data;
    logic             trav_to_tarb_stall;
    logic             tarb_to_tt_valid;
    logic [WIDTH-1:0] tarb_to_tt_data;
    logic             tarb_to_tt_stall;

    modport slave (
        input  sint_to_tarb_valid, sint_to_tarb_data,
        output sint_to_tarb_stall,
        input  ss_to_tarb_valid, ss_to_tarb_data,
        output ss_to_tarb_stall,
        input  trav_to_tarb_valid, trav_to_tarb_data,
        output trav_to_tarb_stall,
        output tarb_to_tt_valid, tarb_to_tt_data,
        input  tarb_to_tt_stall
    );

    modport master (
        output sint_to_tarb_valid, sint_to_tarb_data,
        input  sint_to_tarb_stall,
        output ss_to_tarb_valid, ss_to_tarb_data,
        input  ss_to_tarb_stall,
        output trav_to_tarb_valid, trav_to_tarb_data,
        input  trav_to_tarb_stall,
        input  tarb_to_tt_valid, tarb_to_tt_data,
        output tarb_to_tt_stall
    );
endinterface

// File: rtl/trav_arb.sv
// Traversal arbiter (tarb).
// Merges new rays (scene_int), restarted rays (short stack) and recirculated rays
// (traversal loop) into the traversal pipeline entry. Each source owns a 2-entry FIFO;
// a round-robin arbiter (TRAV -> SS -> SINT -> TRAV) pops one head per cycle into a
// registered output with valid/stall handshake.
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset
//   bus  : trav_arb_if.slave
//          *_to_tarb_valid/data in, *_to_tarb_stall out (registered, = buffer full)
//          tarb_to_tt_valid/data out (registered), tarb_to_tt_stall in
module trav_arb #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned BUF_DEPTH = 2    // fixed at 2; pointers are 1 bit wide
) (
    input logic       clk,
    input logic       rst,
    trav_arb_if.slave bus
);
    localparam int unsigned NSRC     = 3;
    localparam logic [1:0]  SRC_TRAV = 2'd0;
    localparam logic [1:0]  SRC_SS   = 2'd1;
    localparam logic [1:0]  SRC_SINT = 2'd2;
    localparam logic [1:0]  CNT_FULL = 2'(BUF_DEPTH);

    logic [NSRC-1:0]  w_in_valid;
    logic [WIDTH-1:0] w_in_data [NSRC];
    logic [NSRC-1:0]  w_stall;
    logic [NSRC-1:0]  w_nempty;
    logic [NSRC-1:0]  w_pop;
    logic [WIDTH-1:0] w_head [NSRC];

    logic             w_load_en;
    logic             w_gnt;
    logic [1:0]       w_gnt_src;

    logic [1:0]       r_rr;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;

    // Round-robin successor: TRAV -> SS -> SINT -> TRAV.
    function automatic logic [1:0] f_next_src(input logic [1:0] src);
        logic [1:0] nxt;
        unique case (src)
            SRC_TRAV: nxt = SRC_SS;
            SRC_SS:   nxt = SRC_SINT;
            default:  nxt = SRC_TRAV;
        endcase
        return nxt;
    endfunction

    assign w_in_valid[SRC_TRAV] = bus.trav_to_tarb_valid;
    assign w_in_valid[SRC_SS]   = bus.ss_to_tarb_valid;
    assign w_in_valid[SRC_SINT] = bus.sint_to_tarb_valid;
    assign w_in_data[SRC_TRAV]  = bus.trav_to_tarb_data;
    assign w_in_data[SRC_SS]    = bus.ss_to_tarb_data;
    assign w_in_data[SRC_SINT]  = bus.sint_to_tarb_data;

    assign bus.trav_to_tarb_stall = w_stall[SRC_TRAV];
    assign bus.ss_to_tarb_stall   = w_stall[SRC_SS];
    assign bus.sint_to_tarb_stall = w_stall[SRC_SINT];

    // Per-source 2-entry input FIFO.
    for (genvar i = 0; i < NSRC; i++) begin : g_buf
        logic [WIDTH-1:0] r_mem [2];
        logic             r_wptr;
        logic             r_rptr;
        logic [1:0]       r_cnt;
        logic             r_stall;
        logic             w_push;
        logic [1:0]       w_cnt_next;

        // Valid while stalled is ignored, so a full buffer is never written.
        assign w_push      = w_in_valid[i] && !r_stall;
        assign w_stall[i]  = r_stall;
        assign w_nempty[i] = (r_cnt != 2'd0);
        assign w_head[i]   = r_mem[r_rptr];

        always_comb begin
            w_cnt_next = r_cnt;
            if (w_push && !w_pop[i]) begin
                w_cnt_next = r_cnt + 2'd1;
            end else if (!w_push && w_pop[i]) begin
                w_cnt_next = r_cnt - 2'd1;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                r_mem[0] <= '0;
                r_mem[1] <= '0;
                r_wptr   <= 1'b0;
                r_rptr   <= 1'b0;
                r_cnt    <= 2'd0;
                r_stall  <= 1'b0;
            end else begin
                if (w_push) begin
                    r_mem[r_wptr] <= w_in_data[i];
                    r_wptr        <= ~r_wptr;
                end
                if (w_pop[i]) begin
                    r_rptr <= ~r_rptr;
                end
                r_cnt   <= w_cnt_next;
                // Registered from the next count so stall always mirrors a full buffer.
                r_stall <= (w_cnt_next == CNT_FULL);
            end
        end

        a_no_overflow: assert property (@(posedge clk) disable iff (rst)
            !(w_push && r_cnt == CNT_FULL));
        a_no_underflow: assert property (@(posedge clk) disable iff (rst)
            !(w_pop[i] && r_cnt == 2'd0));
    end

    // Arbitration: only when the output register can take a new ray.
    always_comb begin
        logic [1:0] w_cand;
        w_load_en = !r_out_valid || !bus.tarb_to_tt_stall;
        w_gnt     = 1'b0;
        w_gnt_src = r_rr;
        w_pop     = '0;
        w_cand    = r_rr;
        for (int unsigned k = 0; k < NSRC; k++) begin
            if (w_load_en && !w_gnt && w_nempty[w_cand]) begin
                w_gnt     = 1'b1;
                w_gnt_src = w_cand;
            end
            w_cand = f_next_src(w_cand);
        end
        if (w_gnt) begin
            w_pop[w_gnt_src] = 1'b1;
        end
    end

    // Output register; holds while stalled, clears when drained without a new grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_rr        <= SRC_TRAV;
        end else if (w_gnt) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_head[w_gnt_src];
            r_rr        <= f_next_src(w_gnt_src);
        end else if (w_load_en) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.tarb_to_tt_valid = r_out_valid;
    assign bus.tarb_to_tt_data  = r_out_data;
endmodule

// File: tb/tb_trav_arb.sv
// Self-checking bench for trav_arb: directed scenarios plus a long random run, all
// compared cycle by cycle against a queue-based reference model of the arbiter.
// Ray data = {source tag[1:0], id[29:0]} with tag 0=TRAV, 1=SS, 2=SINT.
module tb_trav_arb;
    localparam int unsigned W = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    trav_arb_if #(.WIDTH(W)) bus ();
    trav_arb #(.WIDTH(W), .BUF_DEPTH(2)) dut (.clk(clk), .rst(rst), .bus(bus));

    logic         in_v [3];
    logic [W-1:0] in_d [3];
    logic         dstall;

    assign bus.trav_to_tarb_valid = in_v[0];
    assign bus.trav_to_tarb_data  = in_d[0];
    assign bus.ss_to_tarb_valid   = in_v[1];
    assign bus.ss_to_tarb_data    = in_d[1];
    assign bus.sint_to_tarb_valid = in_v[2];
    assign bus.sint_to_tarb_data  = in_d[2];
    assign bus.tarb_to_tt_stall   = dstall;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state.
    logic [W-1:0] mq [3][$];
    logic         m_out_v;
    logic [W-1:0] m_out_d;
    int           m_rr;
    logic         m_stall [3];
    logic         m_xfer [3];
    logic         m_gnt;

    logic [W-1:0] outq [$];
    int           wait_cnt [3];
    int           max_wait;

    task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [W-1:0] mk(input int src, input int id);
        logic [1:0]  t;
        logic [29:0] n;
        t = src[1:0];
        n = id[29:0];
        return {t, n};
    endfunction

    // One clock edge of the abstract arbiter: grant from the pre-edge queue contents,
    // then accept new rays, then recompute "buffer full" stalls.
    task automatic model_edge();
        int g;
        bit load_en;
        if (rst) begin
            for (int s = 0; s < 3; s++) begin
                mq[s].delete();
                m_stall[s]  = 1'b0;
                m_xfer[s]   = 1'b0;
                wait_cnt[s] = 0;
            end
            m_out_v = 1'b0;
            m_out_d = '0;
            m_rr    = 0;
            m_gnt   = 1'b0;
        end else begin
            g       = -1;
            load_en = !m_out_v || !dstall;
            if (load_en) begin
                for (int k = 0; k < 3; k++) begin
                    if (g < 0 && mq[(m_rr + k) % 3].size() != 0) g = (m_rr + k) % 3;
                end
            end
            m_gnt = (g >= 0);
            if (g >= 0) begin
                m_out_v = 1'b1;
                m_out_d = mq[g].pop_front();
                m_rr    = (g + 1) % 3;
            end else if (load_en) begin
                m_out_v = 1'b0;
            end
            for (int s = 0; s < 3; s++) begin
                m_xfer[s] = in_v[s] && !m_stall[s];
                if (m_xfer[s]) mq[s].push_back(in_d[s]);
            end
            for (int s = 0; s < 3; s++) m_stall[s] = (mq[s].size() == 2);
        end
    endtask

    task automatic compare();
        check_eq("out_valid", bus.tarb_to_tt_valid, m_out_v);
        if (m_out_v) check_eq("out_data", bus.tarb_to_tt_data, m_out_d);
        check_eq("trav_stall", bus.trav_to_tarb_stall, m_stall[0]);
        check_eq("ss_stall", bus.ss_to_tarb_stall, m_stall[1]);
        check_eq("sint_stall", bus.sint_to_tarb_stall, m_stall[2]);
    endtask

    // Advance one clock: log the downstream transfer, step the model, sample 1 ns later.
    task automatic cycle();
        bit ne [3];
        int g;
        if (!rst && bus.tarb_to_tt_valid && !dstall) outq.push_back(bus.tarb_to_tt_data);
        for (int s = 0; s < 3; s++) ne[s] = (mq[s].size() != 0);
        @(posedge clk);
        model_edge();
        #1;
        compare();
        if (m_gnt && bus.tarb_to_tt_valid) begin
            g = int'(bus.tarb_to_tt_data[W-1:W-2]);
            for (int s = 0; s < 3; s++) begin
                if (!ne[s] || s == g) begin
                    wait_cnt[s] = 0;
                end else begin
                    wait_cnt[s]++;
                    if (wait_cnt[s] > max_wait) max_wait = wait_cnt[s];
                end
            end
        end
    endtask

    initial begin
        int nid [3];
        int first_c;
        int last_c;
        int nvalid;
        int n_acc;
        int exp_id [3];
        int src;

        for (int s = 0; s < 3; s++) begin
            in_v[s] = 1'b0;
            in_d[s] = '0;
        end
        dstall   = 1'b0;
        max_wait = 0;
        rst      = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        check_eq("rst_out_data", bus.tarb_to_tt_data, '0);

        // Single sint ray, two-cycle latency.
        repeat (7) cycle();
        in_v[2] = 1'b1;
        in_d[2] = mk(2, 5);
        cycle();
        in_v[2] = 1'b0;
        check_eq("lat_not_yet", bus.tarb_to_tt_valid, 1'b0);
        cycle();
        check_eq("lat_valid", bus.tarb_to_tt_valid, 1'b1);
        check_eq("lat_data", bus.tarb_to_tt_data, mk(2, 5));
        repeat (3) cycle();

        // All three sources always valid: strict TRAV, SS, SINT rotation.
        outq.delete();
        for (int s = 0; s < 3; s++) begin
            nid[s]  = 100 * (s + 1);
            in_v[s] = 1'b1;
            in_d[s] = mk(s, nid[s]);
        end
        repeat (40) begin
            cycle();
            for (int s = 0; s < 3; s++) begin
                if (m_xfer[s]) begin
                    nid[s]++;
                    in_d[s] = mk(s, nid[s]);
                end
            end
        end
        for (int s = 0; s < 3; s++) in_v[s] = 1'b0;
        repeat (8) cycle();
        check_eq("rr_count_ok", 32'(outq.size() >= 24), 1);
        for (int i = 0; i < 24 && i < outq.size(); i++) begin
            check_eq("rr_seq", outq[i], mk(i % 3, 100 * (i % 3 + 1) + i / 3));
        end

        // Downstream stall while sint sends 1..4.
        outq.delete();
        dstall  = 1'b1;
        nid[2]  = 1;
        in_v[2] = 1'b1;
        in_d[2] = mk(2, 1);
        repeat (10) begin
            cycle();
            if (m_xfer[2]) begin
                nid[2]++;
                if (nid[2] <= 4) in_d[2] = mk(2, nid[2]);
                else in_v[2] = 1'b0;
            end
        end
        check_eq("stall_hold_valid", bus.tarb_to_tt_valid, 1'b1);
        check_eq("stall_hold_data", bus.tarb_to_tt_data, mk(2, 1));
        check_eq("stall_sint_high", bus.sint_to_tarb_stall, 1'b1);
        dstall = 1'b0;
        repeat (10) begin
            cycle();
            if (m_xfer[2]) begin
                nid[2]++;
                if (nid[2] <= 4) in_d[2] = mk(2, nid[2]);
                else in_v[2] = 1'b0;
            end
        end
        check_eq("stall_out_count", outq.size(), 4);
        for (int i = 0; i < 4 && i < outq.size(); i++) check_eq("stall_order", outq[i], mk(2, i + 1));

        // SS only, 20 back-to-back rays at 1/cycle.
        outq.delete();
        nid[1]  = 0;
        in_v[1] = 1'b1;
        in_d[1] = mk(1, 0);
        first_c = -1;
        last_c  = -1;
        nvalid  = 0;
        for (int c = 0; c < 26; c++) begin
            cycle();
            if (bus.tarb_to_tt_valid) begin
                if (first_c < 0) first_c = c;
                last_c = c;
                nvalid++;
            end
            if (m_xfer[1]) begin
                nid[1]++;
                if (nid[1] < 20) in_d[1] = mk(1, nid[1]);
                else in_v[1] = 1'b0;
            end
        end
        cycle();
        check_eq("ss_nvalid", nvalid, 20);
        check_eq("ss_no_bubbles", last_c - first_c + 1, 20);
        check_eq("ss_out_count", outq.size(), 20);
        for (int i = 0; i < 20 && i < outq.size(); i++) check_eq("ss_order", outq[i], mk(1, i));

        // Reset with full buffers and a valid output.
        dstall = 1'b1;
        for (int s = 0; s < 3; s++) begin
            in_v[s] = 1'b1;
            in_d[s] = mk(s, 500 + s);
        end
        repeat (8) begin
            cycle();
            for (int s = 0; s < 3; s++) if (m_xfer[s]) in_d[s] = in_d[s] + 1;
        end
        check_eq("pre_rst_valid", bus.tarb_to_tt_valid, 1'b1);
        check_eq("pre_rst_trav_stall", bus.trav_to_tarb_stall, 1'b1);
        for (int s = 0; s < 3; s++) in_v[s] = 1'b0;
        rst = 1'b1;
        cycle();
        rst    = 1'b0;
        dstall = 1'b0;
        check_eq("mid_rst_valid", bus.tarb_to_tt_valid, 1'b0);
        check_eq("mid_rst_stalls", {bus.trav_to_tarb_stall, bus.ss_to_tarb_stall,
                                    bus.sint_to_tarb_stall}, 3'b000);
        cycle();
        check_eq("post_rst_idle", bus.tarb_to_tt_valid, 1'b0);
        in_v[2] = 1'b1;
        in_d[2] = mk(2, 77);
        cycle();
        in_v[2] = 1'b0;
        check_eq("post_rst_lat0", bus.tarb_to_tt_valid, 1'b0);
        cycle();
        check_eq("post_rst_valid", bus.tarb_to_tt_valid, 1'b1);
        check_eq("post_rst_data", bus.tarb_to_tt_data, mk(2, 77));
        repeat (3) cycle();

        // Random traffic: 50% valid on every source, 50% downstream stall.
        outq.delete();
        max_wait = 0;
        n_acc    = 0;
        for (int s = 0; s < 3; s++) begin
            nid[s]    = 1000;
            exp_id[s] = 1000;
            wait_cnt[s] = 0;
        end
        repeat (10000) begin
            for (int s = 0; s < 3; s++) begin
                if (!in_v[s] || m_xfer[s]) begin
                    in_v[s] = 1'($urandom_range(0, 1));
                    if (in_v[s]) begin
                        in_d[s] = mk(s, nid[s]);
                        nid[s]++;
                    end
                end
            end
            dstall = 1'($urandom_range(0, 1));
            cycle();
            for (int s = 0; s < 3; s++) if (m_xfer[s]) n_acc++;
        end
        for (int s = 0; s < 3; s++) in_v[s] = 1'b0;
        dstall = 1'b0;
        repeat (12) cycle();
        check_eq("rand_all_out", outq.size(), n_acc);
        for (int i = 0; i < outq.size(); i++) begin
            src = int'(outq[i][W-1:W-2]);
            if (src > 2) begin
                check_eq("rand_tag", src, 2);
            end else begin
                check_eq("rand_order", outq[i], mk(src, exp_id[src]));
                exp_id[src]++;
            end
        end
        check_eq("rand_max_wait", 32'(max_wait <= 2), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
